// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// one-hot grant vector produced by arb_pick.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IC_RD = 2'd1,
        ARB_DC_RD = 2'd2,
        ARB_DC_WR = 2'd3
    } arb_state_t;

    localparam int GNT_IC    = 0;
    localparam int GNT_DC_RD = 1;
    localparam int GNT_DC_WR = 2;

    typedef logic [2:0] arb_grant_t;

    function automatic arb_state_t grant_state(input arb_grant_t grant);
        arb_state_t st;
        st = ARB_IDLE;
        if (grant[GNT_DC_WR]) begin
            st = ARB_DC_WR;
        end else if (grant[GNT_DC_RD]) begin
            st = ARB_DC_RD;
        end else if (grant[GNT_IC]) begin
            st = ARB_IC_RD;
        end
        return st;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the Icache/Dcache request paths and the memory_sync port.
// slave = arbiter view, master = caches + memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();
    logic              ic_mem_read_req;
    logic [ADDR_W-1:0] ic_mem_read_addr;
    logic [LINE_W-1:0] ic_mem_read_data;
    logic              ic_mem_read_ack;

    logic              dc_mem_read_req;
    logic [ADDR_W-1:0] dc_mem_read_addr;
    logic [LINE_W-1:0] dc_mem_read_data;
    logic              dc_mem_read_ack;

    logic              dc_mem_write_req;
    logic [ADDR_W-1:0] dc_mem_write_addr;
    logic [LINE_W-1:0] dc_mem_write_data;
    logic              dc_mem_write_ack;

    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_in;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_ack;

    modport slave (
        input  ic_mem_read_req, ic_mem_read_addr,
        output ic_mem_read_data, ic_mem_read_ack,
        input  dc_mem_read_req, dc_mem_read_addr,
        output dc_mem_read_data, dc_mem_read_ack,
        input  dc_mem_write_req, dc_mem_write_addr, dc_mem_write_data,
        output dc_mem_write_ack,
        output mem_enable, mem_rw, mem_addr, mem_data_in,
        input  mem_data_out, mem_ack
    );

    modport master (
        output ic_mem_read_req, ic_mem_read_addr,
        input  ic_mem_read_data, ic_mem_read_ack,
        output dc_mem_read_req, dc_mem_read_addr,
        input  dc_mem_read_data, dc_mem_read_ack,
        output dc_mem_write_req, dc_mem_write_addr, dc_mem_write_data,
        input  dc_mem_write_ack,
        input  mem_enable, mem_rw, mem_addr, mem_data_in,
        output mem_data_out, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational request picker. Dcache write always beats Dcache read;
// I vs D is fixed D-first, or alternating when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_rd_req,
    input  logic       dc_wr_req,
    input  logic       last_side,
    output arb_grant_t grant
);
    logic d_req;
    logic pick_d;

    assign d_req = dc_rd_req | dc_wr_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the side not served last time wins (last_side: 0=I, 1=D).
    assign pick_d = d_req & (~ic_req | ~last_side);
`else
    logic unused_last_side;
    assign unused_last_side = last_side;
    assign pick_d = d_req;
`endif

    always_comb begin
        grant = '0;
        if (pick_d) begin
            if (dc_wr_req) begin
                grant[GNT_DC_WR] = 1'b1;
            end else begin
                grant[GNT_DC_RD] = 1'b1;
            end
        end else if (ic_req) begin
            grant[GNT_IC] = 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises Icache refills and Dcache refill/write-back onto one memory_sync
// port with a sticky watchdog. Optional macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output logic               arb_timeout_err
);
    // state     | meaning
    // ARB_IDLE  | no transaction; requests sampled, winner registered
    // ARB_IC_RD | Icache line read in flight
    // ARB_DC_RD | Dcache line read in flight
    // ARB_DC_WR | Dcache write-back in flight

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_grant_t        grant;
    logic              idle;
    logic              grant_take;
    logic              last_side;
    logic [ADDR_W-1:0] grant_addr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;
    logic              mem_rw_q;
    logic [CNT_W-1:0]  wd_cnt;
    logic              err_q;

    assign idle       = (state == ARB_IDLE);
    assign grant_take = idle && (grant != '0);

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_side <= 1'b0;
        end else if (grant_take) begin
            last_side <= ~grant[GNT_IC];
        end
    end
`else
    assign last_side = 1'b0;
`endif

    arb_pick u_pick (
        .ic_req    (bus.ic_mem_read_req),
        .dc_rd_req (bus.dc_mem_read_req),
        .dc_wr_req (bus.dc_mem_write_req),
        .last_side (last_side),
        .grant     (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: state_nxt = grant_state(grant);
            default:  if (bus.mem_ack) state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_addr = bus.ic_mem_read_addr;
        if (grant[GNT_DC_WR]) begin
            grant_addr = bus.dc_mem_write_addr;
        end else if (grant[GNT_DC_RD]) begin
            grant_addr = bus.dc_mem_read_addr;
        end
    end

    // Transaction fields are captured once at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rw_q   <= 1'b0;
        end else if (grant_take) begin
            mem_addr_q <= grant_addr;
            mem_rw_q   <= grant[GNT_DC_WR];
            if (grant[GNT_DC_WR]) begin
                mem_data_q <= bus.dc_mem_write_data;
            end
        end
    end

    // err rises together with the count reaching TIMEOUT; the count then saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (grant_take) begin
            wd_cnt <= '0;
        end else if (!idle && !bus.mem_ack && (wd_cnt != CNT_MAX)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
            if (wd_cnt == CNT_LAST) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_enable       = !idle;
        bus.mem_rw           = mem_rw_q;
        bus.mem_addr         = mem_addr_q;
        bus.mem_data_in      = mem_data_q;
        bus.ic_mem_read_ack  = bus.mem_ack && (state == ARB_IC_RD);
        bus.dc_mem_read_ack  = bus.mem_ack && (state == ARB_DC_RD);
        bus.dc_mem_write_ack = bus.mem_ack && (state == ARB_DC_WR);
        bus.ic_mem_read_data = bus.mem_data_out;
        bus.dc_mem_read_data = bus.mem_data_out;
    end

    assign arb_timeout_err = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level
// model of port ownership; honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    logic err;
    logic [LW-1:0] rd_data;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .arb_timeout_err (err)
    );

    assign bus.mem_data_out = rd_data;

    // Reference model: who owns the port, what it asked for, how long it has waited.
    int            m_owner;   // -1 none, 0 ic read, 1 dc read, 2 dc write
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_wait;
    bit            m_err;
    bit            m_last_d;

    int vecs = 0;
    int miss = 0;
    bit obs_en, obs_ic, obs_dr, obs_dw, obs_err;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(bit ic, bit dr, bit dw, bit last_d);
        int dwin;
        dwin = dw ? 2 : 1;
        if (!ic && !(dr || dw)) return -1;
        if (!ic) return dwin;
        if (!(dr || dw)) return 0;
`ifdef ARB_ROUND_ROBIN_EN
        return last_d ? 0 : dwin;
`else
        return dwin;
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1; m_addr = '0; m_wdata = '0; m_wait = 0; m_err = 0; m_last_d = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, waits a cycle.
    task automatic step();
        bit busy;
        int g;
        #1;
        busy = (m_owner >= 0);
        obs_en = bus.mem_enable; obs_ic = bus.ic_mem_read_ack;
        obs_dr = bus.dc_mem_read_ack; obs_dw = bus.dc_mem_write_ack; obs_err = err;
        chk("mem_enable", bus.mem_enable, busy);
        chk("ic_ack", bus.ic_mem_read_ack, busy && m_owner == 0 && bus.mem_ack);
        chk("dc_rd_ack", bus.dc_mem_read_ack, busy && m_owner == 1 && bus.mem_ack);
        chk("dc_wr_ack", bus.dc_mem_write_ack, busy && m_owner == 2 && bus.mem_ack);
        chk("timeout_err", err, m_err);
        if (busy) begin
            chk("mem_rw", bus.mem_rw, m_owner == 2);
            chk("mem_addr", bus.mem_addr, m_addr);
            if (m_owner == 2) chk("mem_data_in", bus.mem_data_in, m_wdata);
        end
        if (busy && m_owner == 0 && bus.mem_ack) chk("ic_data", bus.ic_mem_read_data, rd_data);
        if (busy && m_owner == 1 && bus.mem_ack) chk("dc_data", bus.dc_mem_read_data, rd_data);
        if (reset) begin
            model_reset();
        end else if (!busy) begin
            g = pick(bus.ic_mem_read_req, bus.dc_mem_read_req, bus.dc_mem_write_req, m_last_d);
            if (g >= 0) begin
                m_owner  = g;
                m_wait   = 0;
                m_last_d = (g != 0);
                m_addr   = (g == 0) ? bus.ic_mem_read_addr :
                           (g == 1) ? bus.dc_mem_read_addr : bus.dc_mem_write_addr;
                if (g == 2) m_wdata = bus.dc_mem_write_data;
            end
        end else if (bus.mem_ack) begin
            m_owner = -1;
        end else begin
            m_wait++;
            if (m_wait >= TO) m_err = 1;
        end
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        reset = 1'b1; bus.mem_ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int seq[$];
        int exp4[4];
        int en_cnt, ackn, t_wr, t_rd, lat, prev;
        bit pend[3];
        bit b;

        reset = 1'b1;
        bus.ic_mem_read_req = 0;  bus.ic_mem_read_addr = '0;
        bus.dc_mem_read_req = 0;  bus.dc_mem_read_addr = '0;
        bus.dc_mem_write_req = 0; bus.dc_mem_write_addr = '0; bus.dc_mem_write_data = '0;
        bus.mem_ack = 0; rd_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_enable", bus.mem_enable, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_rw", bus.mem_rw, 0);
        chk("rst_mem_data_in", bus.mem_data_in, 0);
        chk("rst_err", err, 0);
        @(negedge clk);

        // 1: reset during a Dcache read abandons it
        bus.dc_mem_read_req = 1; bus.dc_mem_read_addr = 32'h300;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; bus.dc_mem_read_req = 0; bus.mem_ack = 1;
        chk("t1_addr_cleared", bus.mem_addr, 0);
        step();
        chk("t1_no_ack", obs_dr, 0);
        bus.mem_ack = 0;

        // 2: lone Icache read, memory answers on the third busy cycle
        bus.ic_mem_read_req = 1; bus.ic_mem_read_addr = 32'h40;
        step();
        en_cnt = 0; ackn = 0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_ack = (k == 2); rd_data = {16{8'hA5}};
            step();
            en_cnt += obs_en; ackn += obs_ic;
        end
        bus.ic_mem_read_req = 0; bus.mem_ack = 0;
        step();
        chk("t2_enable_cycles", en_cnt, 3);
        chk("t2_ic_ack_count", ackn, 1);

        // 3: write-back and refill together -> write first, one idle cycle, read
        bus.dc_mem_write_req = 1; bus.dc_mem_write_addr = 32'h100;
        bus.dc_mem_write_data = {4{32'hDEAD_BEEF}};
        bus.dc_mem_read_req = 1;  bus.dc_mem_read_addr = 32'h200;
        seq.delete(); t_wr = -1; t_rd = -1;
        for (int c = 0; c < 20 && seq.size() < 2; c++) begin
            bus.mem_ack = (m_owner >= 0); rd_data = {4{$urandom}};
            step();
            if (obs_dw) begin seq.push_back(2); t_wr = c; bus.dc_mem_write_req = 0; end
            if (obs_dr) begin seq.push_back(1); t_rd = c; bus.dc_mem_read_req = 0; end
        end
        bus.mem_ack = 0;
        chk("t3_count", seq.size(), 2);
        if (seq.size() == 2) begin
            chk("t3_first_is_write", seq[0], 2);
            chk("t3_second_is_read", seq[1], 1);
            chk("t3_ack_spacing", t_rd - t_wr, 2);
        end

        // 4: Icache and Dcache read held continuously
        reset_cycle();
`ifdef ARB_ROUND_ROBIN_EN
        exp4 = '{1, 0, 1, 0};
`else
        exp4 = '{1, 1, 1, 1};
`endif
        bus.ic_mem_read_req = 1; bus.ic_mem_read_addr = 32'h1000;
        bus.dc_mem_read_req = 1; bus.dc_mem_read_addr = 32'h2000;
        seq.delete();
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            bus.mem_ack = (m_owner >= 0); rd_data = {4{$urandom}};
            step();
            if (obs_ic) seq.push_back(0);
            if (obs_dr) seq.push_back(1);
        end
        bus.ic_mem_read_req = 0; bus.dc_mem_read_req = 0; bus.mem_ack = 0;
        step();
        chk("t4_count", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seq.size()) chk($sformatf("t4_grant%0d", i), seq[i], exp4[i]);

        // 5: watchdog with mem_ack withheld
        reset_cycle();
        bus.ic_mem_read_req = 1; bus.ic_mem_read_addr = 32'h80;
        step();
        for (int bc = 1; bc <= 12; bc++) begin
            step();
            if (bc == 8) chk("t5_err_busy8", obs_err, 0);
            if (bc == 9) chk("t5_err_busy9", obs_err, 1);
        end
        bus.mem_ack = 1; rd_data = {4{32'h1234_5678}};
        step();
        chk("t5_late_ack", obs_ic, 1);
        chk("t5_err_held", obs_err, 1);
        bus.ic_mem_read_req = 0; bus.mem_ack = 0;
        step();

        // 6: spurious mem_ack while idle
        reset_cycle();
        bus.mem_ack = 1;
        step();
        step();
        chk("t6_still_idle", obs_en, 0);
        bus.mem_ack = 0;

        // Randomized traffic with random memory latency
        pend = '{0, 0, 0}; lat = 0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    case (r)
                        0: begin bus.ic_mem_read_req = 1; bus.ic_mem_read_addr = $urandom; end
                        1: begin bus.dc_mem_read_req = 1; bus.dc_mem_read_addr = $urandom; end
                        default: begin
                            bus.dc_mem_write_req = 1; bus.dc_mem_write_addr = $urandom;
                            bus.dc_mem_write_data = {$urandom, $urandom, $urandom, $urandom};
                        end
                    endcase
                end
            end
            if (m_owner >= 0) begin
                bus.mem_ack = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                bus.mem_ack = ($urandom_range(0, 3) == 0);
            end
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 99) == 0);
            prev = m_owner;
            step();
            if (prev < 0 && m_owner >= 0) lat = $urandom_range(0, 3);
            b = obs_ic; if (b) begin pend[0] = 0; bus.ic_mem_read_req = 0; end
            b = obs_dr; if (b) begin pend[1] = 0; bus.dc_mem_read_req = 0; end
            b = obs_dw; if (b) begin pend[2] = 0; bus.dc_mem_write_req = 0; end
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
